// File: rtl/fafc_sar_gen.sv
`timescale 1ns/1ps
// Purpose : fast AFC engine, binary-searches the DCO tuning word by counting divider edges per window.
// Latency : DONE OTW_L*(N+2)+1 REF cycles after the accepted START; result held on OTW_P afterwards.
// Backpres: no flow control; START is ignored while a calibration is running or on the DONE cycle.
//
// Ports:
//   i_ref      reference clock, all logic on its rising edge
//   i_arst     asynchronous active-high reset, aborts any calibration
//   i_start    single-cycle start pulse
//   i_fcw      target frequency ratio, unsigned WI.WF fixed point
//   i_mgn      margin added to the target as (MGN<<8)
//   i_divsel   divider prescale, measured count is shifted left by this bit
//   i_win      window length N in REF cycles (0 behaves as 1)
//   i_cnt      free-running wrapping DCO-divider counter
//   o_otw_p    tuning word to the DCO bank, o_otw_n its complement
//   o_busy     calibration in progress
//   o_done     one-cycle completion pulse
//   o_lock     result valid, held until the next accepted start
//   o_mmd_nrst divider reset, low only during the DONE cycle
module fafc_sar_gen #(
  parameter int OTW_L = 9,
  parameter int CNT_W = 7,
  parameter int WIN_W = 5,
  parameter int WI    = 9,
  parameter int WF    = 16
) (
  input  logic               i_ref,
  input  logic               i_arst,
  input  logic               i_start,
  input  logic [WI+WF-1:0]   i_fcw,
  input  logic [7:0]         i_mgn,
  input  logic               i_divsel,
  input  logic [WIN_W-1:0]   i_win,
  input  logic [CNT_W-1:0]   i_cnt,
  output logic [OTW_L-1:0]   o_otw_p,
  output logic [OTW_L-1:0]   o_otw_n,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_lock,
  output logic               o_mmd_nrst
);

  // Accumulator width, measured-side width after both shifts, target width,
  // target*N width, and a signed error width that holds either side plus sign.
  localparam int SW  = CNT_W + WIN_W + 1;
  localparam int MW  = SW + 1 + WF;
  localparam int FW  = WI + WF;
  localparam int TW  = ((FW > 16) ? FW : 16) + 1;
  localparam int PW  = TW + WIN_W;
  localparam int EW  = ((MW > PW) ? MW : PW) + 1;
  localparam int STW = (OTW_L > 1) ? $clog2(OTW_L) : 1;

  localparam logic [OTW_L-1:0] MID       = OTW_L'(1) << (OTW_L - 1);
  localparam logic [STW-1:0]   LAST_STEP = STW'(OTW_L - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEAS,
    S_DECIDE,
    S_FINAL
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [OTW_L-1:0]   r_code;
  logic [OTW_L-1:0]   r_best_code;
  logic [EW-1:0]      r_best_err;
  logic [STW-1:0]     r_step;
  logic [WIN_W-1:0]   r_mcnt;
  logic [WIN_W-1:0]   r_n;
  logic [FW-1:0]      r_fcw;
  logic [7:0]         r_mgn;
  logic               r_divsel;
  logic [CNT_W-1:0]   r_cnt_prev;
  logic [SW-1:0]      r_s;
  logic               r_lock;

  logic [CNT_W-1:0]   w_delta;
  logic [EW-1:0]      w_meas_base;
  logic [EW-1:0]      w_meas;
  logic [EW-1:0]      w_tgt;
  logic [EW-1:0]      w_prod;
  logic [EW-1:0]      w_diff;
  logic [EW-1:0]      w_abs;
  logic               w_neg;
  logic               w_take;
  logic               w_last;
  logic               w_meas_done;
  logic [OTW_L-1:0]   w_amt;
  logic [OTW_L-1:0]   w_best_code_nxt;

  // Modulo subtraction absorbs counter wrap as long as it moves < 2^CNT_W per cycle.
  assign w_delta     = i_cnt - r_cnt_prev;

  assign w_meas_base = EW'(r_s) << WF;
  assign w_meas      = r_divsel ? (w_meas_base << 1) : w_meas_base;
  assign w_tgt       = EW'(r_fcw) + (EW'(r_mgn) << 8);
  assign w_prod      = w_tgt * EW'(r_n);
  assign w_diff      = w_meas - w_prod;
  assign w_neg       = w_diff[EW-1];
  assign w_abs       = w_neg ? (~w_diff + EW'(1)) : w_diff;

  // '<=' so that on equal error the later (current) code wins.
  assign w_take          = (w_abs <= r_best_err);
  assign w_best_code_nxt = w_take ? r_code : r_best_code;
  assign w_last          = (r_step == LAST_STEP);
  assign w_meas_done     = (r_mcnt == (r_n - WIN_W'(1)));
  // Step k moves the code by 1<<(OTW_L-2-k), i.e. MID>>(k+1).
  assign w_amt           = MID >> (r_step + STW'(1));

  always_ff @(posedge i_ref or posedge i_arst) begin
    if (i_arst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_mmd_nrst  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        o_busy      = 1'b1;
        w_state_nxt = S_MEAS;
      end
      S_MEAS: begin
        o_busy = 1'b1;
        if (w_meas_done) w_state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        o_busy      = 1'b1;
        w_state_nxt = w_last ? S_FINAL : S_SETTLE;
      end
      S_FINAL: begin
        o_done      = 1'b1;
        o_mmd_nrst  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_ref or posedge i_arst) begin
    if (i_arst) begin
      r_code      <= MID;
      r_best_code <= MID;
      r_best_err  <= '1;
      r_step      <= '0;
      r_mcnt      <= '0;
      r_n         <= WIN_W'(1);
      r_fcw       <= '0;
      r_mgn       <= '0;
      r_divsel    <= 1'b0;
      r_cnt_prev  <= '0;
      r_s         <= '0;
      r_lock      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_fcw      <= i_fcw;
            r_mgn      <= i_mgn;
            r_divsel   <= i_divsel;
            r_n        <= (i_win == '0) ? WIN_W'(1) : i_win;
            r_code     <= MID;
            r_step     <= '0;
            r_best_err <= '1;
            r_lock     <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_cnt_prev <= i_cnt;
          r_s        <= '0;
          r_mcnt     <= '0;
        end
        S_MEAS: begin
          r_s        <= r_s + SW'(w_delta);
          r_cnt_prev <= i_cnt;
          r_mcnt     <= r_mcnt + WIN_W'(1);
        end
        S_DECIDE: begin
          if (w_take) begin
            r_best_err  <= w_abs;
            r_best_code <= r_code;
          end
          if (w_last) begin
            // Best code goes out on the edge into FINAL so it is valid with DONE.
            r_code <= w_best_code_nxt;
            r_lock <= 1'b1;
          end else begin
            r_code <= w_neg ? (r_code + w_amt) : (r_code - w_amt);
            r_step <= r_step + STW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_otw_p = r_code;
  assign o_otw_n = ~r_code;
  assign o_lock  = r_lock;

endmodule

// File: doc/fafc_sar_gen.md
# fafc_sar_gen

Parametrised fast auto-frequency-control engine that binary-searches the DCO tuning word before the fine PLL loop is enabled. It sits between the SPI configuration registers, the free-running DCO-divider counter and the DCO bank driver. Each trial code is measured by counting DCO-divider edges over a programmable window of REF cycles. Unlike the previous generation, it has the following:

- OTW, counter and window widths are parameters.
- START/BUSY/DONE handshake with restart capability.
- Best-of selection: the final code is the measured code with minimum |frequency error|, not simply the last SAR code.

## Interface
Parameters:
- OTW_L, 9, tuning-word width (SAR steps = OTW_L)
- CNT_W, 7, width of wrapping DCO-divider counter input
- WIN_W, 5, width of window-length input
- WI, 9, FCW integer bits
- WF, 16, FCW fractional bits

Ports:
- REF  in  1  reference clock; all logic on rising edge
- ARST  in  1  asynchronous, active-high reset
- START  in  1  single-cycle pulse, starts calibration; ignored while BUSY=1
- FCW  in  WI+WF  target frequency ratio, unsigned fixed point
- MGN  in  8  margin; target = FCW + (MGN<<8)
- DIVSEL  in  1  divider prescale; measured count is shifted left by DIVSEL
- WIN  in  WIN_W  window length N in REF cycles; 0 is treated as 1
- CNT  in  CNT_W  free-running divider counter, wraps mod 2^CNT_W
- OTW_P  out  OTW_L  tuning word to DCO bank
- OTW_N  out  OTW_L  always equal to ~OTW_P
- BUSY  out  1  high from the cycle after START until DONE
- DONE  out  1  one-cycle pulse at completion
- LOCK  out  1  high after DONE until the next accepted START
- MMD_NRST  out  1  low for exactly the DONE cycle, otherwise high

## Operation
- FCW, MGN, DIVSEL and WIN are latched at the accepted START. Changes during BUSY have no effect.
- States are IDLE → SETTLE → MEAS → DECIDE, which repeats for OTW_L steps, → FINAL → IDLE.
- IDLE: OTW_P holds its value.
  - An accepted START sets code = 1<<(OTW_L-1), step = 0, best_err = max, LOCK = 0 and BUSY = 1, then moves to SETTLE.
- SETTLE (1 cycle): samples cnt_prev = CNT and clears the accumulator S. The DCO has one cycle to settle on the new code.
- MEAS (N cycles): each cycle applies S += (CNT - cnt_prev) mod 2^CNT_W, then cnt_prev = CNT.
  - S width is CNT_W+WIN_W+1 and never overflows.
- DECIDE (1 cycle):
  - Error: err = ((S<<DIVSEL)<<WF) - (FCW + (MGN<<8))*N, signed, with full width and no truncation.
  - Best-of update: if |err| <= best_err, then best_err = |err| and best_code = code. Ties go to the later code.
  - SAR update:
    - If step < OTW_L-1: when err >= 0, code -= 1<<(OTW_L-step-2); otherwise code += that amount. Then step++ and go to SETTLE.
    - If step = OTW_L-1: go to FINAL.
- FINAL (1 cycle): OTW_P = best_code, DONE = 1, MMD_NRST = 0, BUSY = 0, LOCK = 1. Then go to IDLE.
- Code arithmetic never wraps. The reachable code range is 1 .. 2^OTW_L-1.
- ARST at any time, including mid-measurement, forces every output to its reset value and the state to IDLE. The in-flight result is discarded.

## Timing
- Reset values: OTW_P = 1<<(OTW_L-1), OTW_N = ~OTW_P, BUSY = 0, DONE = 0, LOCK = 0, MMD_NRST = 1. Internal state is IDLE.
- START sampled at edge t0 → OTW_P = mid-code and BUSY = 1 from t0+1.
- Each step takes N+2 cycles. OTW_P changes only on the edge leaving DECIDE and on the FINAL edge.
- DONE asserts at t0 + OTW_L*(N+2) + 1 (t0+55 for OTW_L=9, N=4) and lasts one cycle.
- A START coincident with DONE is ignored. A START on the first IDLE cycle afterwards is accepted.
- CNT is sampled synchronously to REF. Wrap-around is handled by the modulo subtraction, provided the per-cycle increment is < 2^CNT_W.

## Test plan
- Nominal search:
  - Setup: OTW_L=9, N=4, DIVSEL=0, MGN=0, FCW=40.0. The DCO model advances CNT by code/8 per REF cycle, with fractional carry and 7-bit wrap.
  - Required: OTW_P=320 and OTW_N=~320 at DONE, DONE at t0+55, and MMD_NRST low only in that cycle.
- Saturation high: FCW=127.0 with the same model → every step adds, and final OTW_P=511.
- Saturation low: FCW=0 → every step subtracts, and final OTW_P=1.
- Best-of and ties:
  - Setup: the model gives equal |err| for codes 320 and 321.
  - Required: final code is the later-measured one, and it differs from the raw SAR end code when that code is worse.
- Handshake:
  - START pulses while BUSY → ignored, and DONE timing is unchanged.
  - WIN=0 → treated as N=1, and DONE at t0+28.
- Reset mid-MEAS of step 3: ARST pulse → OTW_P=256, BUSY=0, LOCK=0. A subsequent START produces the nominal result.
